// File: rtl/loop_decode.sv
// Decode stage: classifies 16-bit instructions, resolves loop branches against a
// hardware return stack in the same cycle, and issues registered micro-ops.
module loop_decode #(
  parameter int STACK_DEPTH = 16,
  parameter int SP_W        = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ins,
  input  logic [15:0] ins_pc,
  input  logic        cell_zero,
  input  logic        ex_stall,
  output logic        branch_en,
  output logic [15:0] branch_val,
  output logic        stall,
  output logic        ex_valid,
  output logic [2:0]  ex_op,
  output logic [7:0]  ex_imm,
  output logic        halted,
  output logic        err
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0] OPC_ADD  = 4'd1;
  localparam logic [3:0] OPC_MOVE = 4'd2;
  localparam logic [3:0] OPC_LB   = 4'd3;
  localparam logic [3:0] OPC_LE   = 4'd4;
  localparam logic [3:0] OPC_OUT  = 4'd5;
  localparam logic [3:0] OPC_IN   = 4'd6;
  localparam logic [3:0] OPC_HALT = 4'd7;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] imm;
  } uop_t;

  uop_t            uop_q, uop_d;
  logic            ex_valid_q, ex_valid_d;
  logic            halted_q, err_q;
  logic [SP_W-1:0] sp_q;
  logic [15:0]     stk_q [STACK_DEPTH];

  logic [3:0]       opc;
  logic             is_loop, hazard, sp_full, sp_empty;
  logic             push, pop, issue, set_err, set_halt;
  logic [IDX_W-1:0] top_idx;

  assign opc      = ins[15:12];
  assign is_loop  = (opc == OPC_LB) || (opc == OPC_LE);
  assign sp_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign sp_empty = (sp_q == '0);
  assign top_idx  = IDX_W'(sp_q - 1'b1);

  // cell_zero is stale while a cell-modifying op is still in the ex register
  assign hazard = ex_valid_q && is_loop &&
                  (uop_q.op == OPC_ADD[2:0] || uop_q.op == OPC_MOVE[2:0] ||
                   uop_q.op == OPC_IN[2:0]);
  assign stall  = halted_q || err_q || ex_stall || hazard;

  always_comb begin
    branch_en  = 1'b0;
    branch_val = 16'h0000;
    push       = 1'b0;
    pop        = 1'b0;
    issue      = 1'b0;
    set_err    = 1'b0;
    set_halt   = 1'b0;
    uop_d      = uop_q;
    if (!stall) begin
      case (opc)
        OPC_ADD, OPC_MOVE: begin
          issue = 1'b1;
          uop_d = '{op: opc[2:0], imm: ins[7:0]};
        end
        OPC_OUT, OPC_IN: begin
          issue = 1'b1;
          uop_d = '{op: opc[2:0], imm: 8'h00};
        end
        OPC_LB: begin
          if (cell_zero) begin
            branch_en  = 1'b1;
            branch_val = ins_pc + {4'h0, ins[11:0]} + 16'd1;
          end else if (sp_full) begin
            set_err = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        OPC_LE: begin
          if (sp_empty) begin
            set_err = 1'b1;
          end else if (!cell_zero) begin
            branch_en  = 1'b1;
            branch_val = stk_q[top_idx];
          end else begin
            pop = 1'b1;
          end
        end
        OPC_HALT: set_halt = 1'b1;
        default: ;
      endcase
    end
    // ex_stall freezes the ex register; any other stall issues a bubble
    ex_valid_d = ex_stall ? ex_valid_q : issue;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      uop_q      <= '0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      sp_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      if (issue) uop_q <= uop_d;
      if (push) sp_q <= sp_q + 1'b1;
      else if (pop) sp_q <= sp_q - 1'b1;
      err_q    <= err_q | set_err;
      halted_q <= halted_q | set_halt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stk_q[sp_q[IDX_W-1:0]] <= ins_pc + 16'd1;
  end

  assign ex_valid = ex_valid_q;
  assign ex_op    = uop_q.op;
  assign ex_imm   = uop_q.imm;
  assign halted   = halted_q;
  assign err      = err_q;

endmodule

// File: tb/tb_loop_decode.sv
// Scoreboard bench for loop_decode: directed vectors push expected micro-ops,
// a monitor pops and compares them as the ex register presents them.
module tb_loop_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ins = 16'h0000;
  logic [15:0] ins_pc = 16'h0000;
  logic        cell_zero = 1'b0;
  logic        ex_stall = 1'b0;
  logic        branch_en, stall, ex_valid, halted, err;
  logic [15:0] branch_val;
  logic [2:0]  ex_op;
  logic [7:0]  ex_imm;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q [$];

  loop_decode #(.STACK_DEPTH(16), .SP_W(5)) dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_pc(ins_pc), .cell_zero(cell_zero),
    .ex_stall(ex_stall), .branch_en(branch_en), .branch_val(branch_val),
    .stall(stall), .ex_valid(ex_valid), .ex_op(ex_op), .ex_imm(ex_imm),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one instruction for one cycle and check the combinational outputs.
  task automatic step(input logic [15:0] i, input logic [15:0] pc, input logic cz,
                      input logic exs, input logic e_st, input logic e_br,
                      input logic [15:0] e_bv, input logic iss,
                      input logic [2:0] op, input logic [7:0] imm);
    @(negedge clk);
    ins = i; ins_pc = pc; cell_zero = cz; ex_stall = exs;
    #1;
    chk("stall", stall, e_st);
    chk("branch_en", branch_en, e_br);
    chk("branch_val", branch_val, e_bv);
    if (iss) exp_q.push_back({op, imm});
  endtask

  task automatic do_reset();
    @(negedge clk);
    ins = 16'h0000; cell_zero = 1'b0; ex_stall = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Monitor: a micro-op is new only if the ex register was allowed to load at this edge.
  always @(posedge clk) begin
    logic acc;
    logic [10:0] e;
    acc = !ex_stall && !rst;
    #1;
    if (acc && ex_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL uop_unexpected: got op %0d imm %0h, none expected", ex_op, ex_imm);
      end else begin
        e = exp_q.pop_front();
        chk("ex_op", {29'd0, ex_op}, {29'd0, e[10:8]});
        chk("ex_imm", {24'd0, ex_imm}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    // Reset state
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_op", ex_op, 0);
    chk("rst_ex_imm", ex_imm, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    #1 rst = 1'b0;

    // Straight line
    step(16'h1005, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 3'd1, 8'h05);
    step(16'h20FF, 16'h0001, 0, 0, 0, 0, 16'h0000, 1, 3'd2, 8'hFF);
    step(16'h5000, 16'h0002, 0, 0, 0, 0, 16'h0000, 1, 3'd5, 8'h00);
    step(16'h0000, 16'h0003, 0, 0, 0, 0, 16'h0000, 0, 3'd0, 8'h00);
    step(16'h0000, 16'h0004, 0, 0, 0, 0, 16'h0000, 0, 3'd0, 8'h00);
    chk("nop_bubble", ex_valid, 0);

    // Loop taken then fall through
    step(16'h3000, 16'h0010, 0, 0, 0, 0, 16'h0000, 0, 3'd0, 8'h00);
    step(16'h4000, 16'h0012, 0, 0, 0, 1, 16'h0011, 0, 3'd0, 8'h00);
    step(16'h4000, 16'h0012, 0, 0, 0, 1, 16'h0011, 0, 3'd0, 8'h00);
    step(16'h4000, 16'h0012, 1, 0, 0, 0, 16'h0000, 0, 3'd0, 8'h00);

    // Skip: no push, so the next push lands in slot 0 and is the top
    step(16'h3005, 16'h0020, 1, 0, 0, 1, 16'h0026, 0, 3'd0, 8'h00);
    step(16'h3000, 16'h0030, 0, 0, 0, 0, 16'h0000, 0, 3'd0, 8'h00);
    step(16'h4000, 16'h0031, 0, 0, 0, 1, 16'h0031, 0, 3'd0, 8'h00);
    step(16'h4000, 16'h0031, 1, 0, 0, 0, 16'h0000, 0, 3'd0, 8'h00);
    chk("no_err_balanced", err, 0);

    // Skip with 16-bit wrap
    step(16'h3FFF, 16'hF800, 1, 0, 0, 1, 16'h0800, 0, 3'd0, 8'h00);

    // Hazards: one stall cycle, then the repeated ins resolves
    step(16'h1003, 16'h0040, 0, 0, 0, 0, 16'h0000, 1, 3'd1, 8'h03);
    step(16'h3000, 16'h0041, 0, 0, 1, 0, 16'h0000, 0, 3'd0, 8'h00);
    step(16'h3000, 16'h0041, 0, 0, 0, 0, 16'h0000, 0, 3'd0, 8'h00);
    step(16'h1001, 16'h0043, 0, 0, 0, 0, 16'h0000, 1, 3'd1, 8'h01);
    step(16'h4000, 16'h0044, 0, 0, 1, 0, 16'h0000, 0, 3'd0, 8'h00);
    step(16'h4000, 16'h0044, 0, 0, 0, 1, 16'h0042, 0, 3'd0, 8'h00);
    step(16'h4000, 16'h0044, 1, 0, 0, 0, 16'h0000, 0, 3'd0, 8'h00);

    // ex_stall freezes the ex register for 3 cycles
    step(16'h10FE, 16'h0050, 0, 0, 0, 0, 16'h0000, 1, 3'd1, 8'hFE);
    for (int k = 0; k < 3; k++) begin
      step(16'h2002, 16'h0051, 0, 1, 1, 0, 16'h0000, 0, 3'd0, 8'h00);
      chk("frz_valid", ex_valid, 1);
      chk("frz_op", ex_op, 1);
      chk("frz_imm", ex_imm, 8'hFE);
    end
    step(16'h2002, 16'h0051, 0, 0, 0, 0, 16'h0000, 1, 3'd2, 8'h02);
    step(16'h6000, 16'h0052, 0, 0, 0, 0, 16'h0000, 1, 3'd6, 8'h00);

    // HALT is sticky
    step(16'h7000, 16'h0053, 0, 0, 0, 0, 16'h0000, 0, 3'd0, 8'h00);
    step(16'h1009, 16'h0054, 0, 0, 1, 0, 16'h0000, 0, 3'd0, 8'h00);
    chk("halted", halted, 1);
    step(16'h3000, 16'h0054, 1, 0, 1, 0, 16'h0000, 0, 3'd0, 8'h00);
    chk("halt_bubble", ex_valid, 0);

    // Overflow: 17th nested push faults
    do_reset();
    chk("halt_cleared", halted, 0);
    for (int k = 0; k < 16; k++)
      step(16'h3000, 16'h0100 + 16'(k), 0, 0, 0, 0, 16'h0000, 0, 3'd0, 8'h00);
    chk("no_err_full", err, 0);
    step(16'h3000, 16'h0110, 0, 0, 0, 0, 16'h0000, 0, 3'd0, 8'h00);
    step(16'h0000, 16'h0111, 0, 0, 1, 0, 16'h0000, 0, 3'd0, 8'h00);
    chk("overflow_err", err, 1);
    step(16'h4000, 16'h0112, 0, 0, 1, 0, 16'h0000, 0, 3'd0, 8'h00);

    // Async reset mid-cycle with a live micro-op and a pushed loop
    do_reset();
    step(16'h3000, 16'h0060, 0, 0, 0, 0, 16'h0000, 0, 3'd0, 8'h00);
    step(16'h1077, 16'h0061, 0, 0, 0, 0, 16'h0000, 1, 3'd1, 8'h77);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_ex_valid", ex_valid, 0);
    chk("arst_ex_op", ex_op, 0);
    chk("arst_ex_imm", ex_imm, 0);
    chk("arst_err", err, 0);
    rst = 1'b0;

    // Stack was cleared: LOOP_END underflows
    step(16'h4000, 16'h0062, 0, 0, 0, 0, 16'h0000, 0, 3'd0, 8'h00);
    step(16'h0000, 16'h0063, 0, 0, 1, 0, 16'h0000, 0, 3'd0, 8'h00);
    chk("underflow_err", err, 1);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
